// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// New values wait in a shadow register and are committed at frame boundaries.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int GAP        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    lz_blank,
    input  logic                    ld_valid,
    input  logic [4*NUM_DIGITS-1:0] ld_data,
    output logic                    ld_ready,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [3:0]              nibble_q, nibble_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pend_q, pend_d;

    logic                    boundary;
    logic [IW-1:0]           idx_next;
    logic [NUM_DIGITS-1:0]   blank_v;

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Wrap edge from the last slot of the top digit back to digit 0.
    assign boundary = ena && (idx_q == IDX_LAST) &&
                      ((state_q == S_SHOW && cnt_q == DWELL_LAST && GAP == 0) ||
                       (state_q == S_GAP && cnt_q == GAP_LAST));

    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        disp_d   = disp_q;
        if (pend_q && (state_q == S_IDLE || boundary)) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end else if (ld_valid && !pend_q) begin
            shadow_d = ld_data;
            pend_d   = 1'b1;
        end
    end

    // Blank digit i when every nibble from i upward is zero; digit 0 never.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_v  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (disp_d[4*i +: 4] == 4'h0);
            blank_v[i] = lz_blank && all_zero;
        end
    end

    always_comb begin
        logic show;
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        dig_sel_d    = dig_sel_q;
        nibble_d     = nibble_q;
        frame_done_d = boundary;
        show         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idx_d     = '0;
                cnt_d     = '0;
                dig_sel_d = '0;
                if (ena) begin
                    state_d = S_SHOW;
                    show    = 1'b1;
                end
            end
            S_SHOW: begin
                if (!ena) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    dig_sel_d = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        dig_sel_d = '0;
                    end else begin
                        idx_d = idx_next;
                        show  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (!ena) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    dig_sel_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    idx_d   = idx_next;
                    show    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                cnt_d     = '0;
                dig_sel_d = '0;
            end
        endcase
        if (show) begin
            dig_sel_d = blank_v[idx_d] ? '0 : (NUM_DIGITS'(1) << idx_d);
            nibble_d  = disp_d[4*idx_d +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            dig_sel_q    <= '0;
            nibble_q     <= '0;
            frame_done_q <= 1'b0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dig_sel_q    <= dig_sel_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
        end
    end

    assign ld_ready   = !pend_q;
    assign nibble_out = nibble_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl (4 digits, dwell 8, gap 2).
// Expected slot patterns come from a small frame model inside the bench.
module tb_seven_segment_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        lz_blank;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [3:0]  nibble_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks = 0;
    int errs   = 0;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS(4),
        .DWELL     (8),
        .GAP       (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .lz_blank  (lz_blank),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .nibble_out(nibble_out),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles of a frame starting at its first SHOW sample.
    task automatic frame(input string tag, input logic [15:0] v,
                         input logic lz, input logic fd0, input int ncyc,
                         input int rdy_lo,
                         input int a0k, input logic a0v, input logic [15:0] a0d,
                         input int a1k, input logic a1v, input logic [15:0] a1d);
        for (int k = 0; k < ncyc; k++) begin
            int s;
            int c;
            logic blank;
            logic [3:0] exp_sel;
            logic [15:0] sh;
            logic [3:0] nib;
            s       = k / 10;
            c       = k % 10;
            sh      = v >> (4 * s);
            nib     = sh[3:0];
            blank   = lz && (s > 0) && (sh == 16'h0);
            exp_sel = (c < 8 && !blank) ? (4'b0001 << s) : 4'b0000;
            chk($sformatf("%s sel k%0d", tag, k), 32'(dig_sel), 32'(exp_sel));
            chk($sformatf("%s fd k%0d", tag, k), 32'(frame_done),
                32'((k == 0) ? fd0 : 1'b0));
            chk($sformatf("%s rdy k%0d", tag, k), 32'(ld_ready),
                32'((k < rdy_lo) ? 1'b1 : 1'b0));
            if (c < 8)
                chk($sformatf("%s nib k%0d", tag, k), 32'(nibble_out), 32'(nib));
            if (k == a0k) begin
                ld_valid = a0v;
                ld_data  = a0d;
            end
            if (k == a1k) begin
                ld_valid = a1v;
                ld_data  = a1d;
            end
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        ena      = 1'b1;
        lz_blank = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        step();
        step();
        step();
        chk("rst sel", 32'(dig_sel), 32'h0);
        chk("rst nib", 32'(nibble_out), 32'h0);
        chk("rst fd", 32'(frame_done), 32'h0);
        chk("rst rdy", 32'(ld_ready), 32'h1);

        ena      = 1'b0;
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("post-rst rdy", 32'(ld_ready), 32'h1);
        chk("post-rst sel", 32'(dig_sel), 32'h0);

        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step();
        ld_valid = 1'b0;
        chk("idle accept rdy", 32'(ld_ready), 32'h0);
        step();
        chk("idle commit rdy", 32'(ld_ready), 32'h1);
        chk("idle sel", 32'(dig_sel), 32'h0);

        ena = 1'b1;
        step();
        frame("f1", 16'h1234, 1'b0, 1'b0, 40, 99,
              -1, 1'b0, 16'h0, -1, 1'b0, 16'h0);
        frame("f2", 16'h1234, 1'b0, 1'b1, 40, 13,
              12, 1'b1, 16'h5678, 13, 1'b1, 16'h0070);
        lz_blank = 1'b1;
        frame("f3", 16'h5678, 1'b1, 1'b1, 40, 1,
              1, 1'b0, 16'h0070, -1, 1'b0, 16'h0);
        frame("f4", 16'h0070, 1'b1, 1'b1, 40, 6,
              5, 1'b1, 16'h0000, 6, 1'b0, 16'h0000);
        frame("f5", 16'h0000, 1'b1, 1'b1, 40, 99,
              -1, 1'b0, 16'h0, -1, 1'b0, 16'h0);
        lz_blank = 1'b0;
        frame("f6", 16'h0000, 1'b0, 1'b1, 22, 4,
              3, 1'b1, 16'h9ABC, 4, 1'b0, 16'h9ABC);

        ena = 1'b0;
        step();
        chk("drop sel", 32'(dig_sel), 32'h0);
        chk("drop fd", 32'(frame_done), 32'h0);
        chk("drop rdy", 32'(ld_ready), 32'h0);
        step();
        chk("idle2 rdy", 32'(ld_ready), 32'h1);
        chk("idle2 sel", 32'(dig_sel), 32'h0);
        chk("idle2 fd", 32'(frame_done), 32'h0);
        step();
        chk("idle3 fd", 32'(frame_done), 32'h0);

        ena = 1'b1;
        step();
        frame("f7", 16'h9ABC, 1'b0, 1'b0, 40, 99,
              39, 1'b1, 16'h2222, -1, 1'b0, 16'h0);
        ld_valid = 1'b0;
        chk("f8 fd", 32'(frame_done), 32'h1);
        chk("f8 sel", 32'(dig_sel), 32'h1);
        chk("f8 nib", 32'(nibble_out), 32'hC);
        chk("f8 rdy", 32'(ld_ready), 32'h0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async sel", 32'(dig_sel), 32'h0);
        chk("async nib", 32'(nibble_out), 32'h0);
        chk("async fd", 32'(frame_done), 32'h0);
        chk("async rdy", 32'(ld_ready), 32'h1);
        #1;
        rst_n = 1'b1;
        step();
        chk("restart sel", 32'(dig_sel), 32'h1);
        chk("restart nib", 32'(nibble_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_ctrl.md
# seven_segment_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It holds an NUM_DIGITS-nibble display value and drives one digit at a time with its 4-bit code. The code goes to an external hex-to-segment decoder (the same decoder used by the single-digit seconds counter), and the matching one-hot digit enable goes to the display. New values arrive over a valid/ready load port and are committed only at frame boundaries, so the display never shows a half-updated value.

## Interface
- NUM_DIGITS, 4: number of display digits (2..8); digit 0 is least significant.
- DWELL, 1000: cycles each digit is driven per scan slot (≥1).
- GAP, 2: blanking cycles after each digit slot, all enables off, to prevent ghosting (≥0).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  scan enable; low forces idle (all digits off).
- lz_blank  in  1  leading-zero blanking enable.
- ld_valid  in  1  load request.
- ld_data  in  4*NUM_DIGITS  new display value; nibble i drives digit i.
- ld_ready  out  1  shadow register free; transfer occurs when ld_valid && ld_ready at a rising edge.
- nibble_out  out  4  code for the active digit, to the segment decoder.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high; all-zero when blanked.
- frame_done  out  1  one-cycle pulse at the end of each full scan frame.

## Operation
- Storage:
  - shadow register plus pend flag.
  - disp register holds the committed display value.
  - ld_ready = !pend (combinational from the flop).
- Accept: when ld_valid && ld_ready, set shadow <= ld_data and pend <= 1. While pend=1, ld_ready=0 and the requester must hold ld_valid/ld_data.
- Commit (disp <= shadow, pend <= 0) happens on either of:
  - the frame-boundary edge;
  - any edge in IDLE with pend=1.
- Accept and commit never coincide, because accept requires pend=0.
- FSM states:
  - IDLE: dig_sel=0, digit index=0, count=0. Exits to SHOW when ena=1.
  - SHOW: dig_sel=one-hot(index) unless blanked; nibble_out=disp[index]. Stays DWELL cycles, then moves to GAP, or to SHOW of the next index if GAP=0.
  - GAP: dig_sel=0; nibble_out holds its value. Stays GAP cycles, then moves to SHOW of index+1.
- Index advance: index wraps NUM_DIGITS-1 → 0. The wrap edge is the frame boundary, where commit occurs and frame_done pulses.
- ena=0 in SHOW/GAP: go to IDLE on the next edge; index and count return to 0. No frame_done is issued.
- Leading-zero blanking: digit i (i≥1) is blanked when lz_blank=1 and disp nibbles i..NUM_DIGITS-1 are all zero.
  - A blanked digit still occupies its full slot timing, with dig_sel=0.
  - Digit 0 is never blanked.
- Count width: $clog2(max(DWELL,GAP)+1); count compares against DWELL-1 / GAP-1.

## Timing
- All outputs except ld_ready are registered and change on the same edge as the state change.
- Reset values (asynchronous on rst_n low):
  - state IDLE; dig_sel=0; nibble_out=0; frame_done=0.
  - ld_ready=1 (pend=0); disp=0; shadow=0; index=0; count=0.
- First SHOW appears on the edge after ena is sampled high; dig_sel=one-hot(0) from that edge.
- Frame length is NUM_DIGITS*(DWELL+GAP) cycles. frame_done is high for exactly the one cycle following the last GAP (or SHOW) of digit NUM_DIGITS-1.
- Commit-to-display latency:
  - a new disp value appears on nibble_out in the first SHOW after the boundary;
  - worst-case wait from accept is one frame;
  - in IDLE, commit is one cycle after accept.
- ld_ready rises on the commit edge; a back-to-back load can be accepted on that edge+1.
- Reset deassertion mid-frame restarts in IDLE. No output glitches beyond the reset values.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, DWELL=8, GAP=2.
- Reset: hold rst_n=0 with ld_valid=1 and ena=1 → dig_sel=0000, nibble_out=0, frame_done=0, ld_ready=1, and no accept occurs. Assert rst_n low mid-frame without clk → outputs return to reset values immediately.
- Load in IDLE, then scan:
  - ena=0, load 0x1234 → ld_ready low for 1 cycle, then high.
  - ena=1 → dig_sel=0001/nibble 4 for 8 cycles, 0000 for 2, then 0010/3, 0100/2, 1000/1.
  - frame_done pulses 40 cycles after the first SHOW edge; the scan repeats.
- Mid-frame load: while displaying 0x1234, load 0x5678 during digit 1 → 0x1234 digits unchanged to frame end, ld_ready=0 until the boundary, first SHOW of the next frame shows nibble 8.
  - A second ld_valid held during this period is accepted on the boundary+1 edge.
- Leading-zero blanking: lz_blank=1.
  - disp 0x0070 → slots 3,2 have dig_sel=0; slot 1 shows 7; slot 0 shows 0.
  - disp 0x0000 → only dig_sel=0001 ever asserts.
  - lz_blank=0 → all four digits enable.
- ena drop: deassert ena at cycle 3 of digit 2 SHOW → dig_sel=0000 on the next edge, no frame_done.
  - Reassert → restart at digit 0 with a full 8-cycle dwell.
  - A pending load commits during IDLE.
